// File: rtl/preg_free_list_if.sv
// Rename/retire-side bundle of the physical-register free list.
// The slave side is the free list; the master side is rename plus ROB retire.
interface preg_free_list_if;
  logic       alloc_req;
  logic       alloc_valid;
  logic [5:0] alloc_preg;
  logic       stall;
  logic [1:0] rel_valid;
  logic [5:0] rel_preg0;
  logic [5:0] rel_preg1;
  logic       ready;
  logic [5:0] free_count;
  logic       err;

  modport master (
    output alloc_req, rel_valid, rel_preg0, rel_preg1,
    input  alloc_valid, alloc_preg, stall, ready, free_count, err
  );

  modport slave (
    input  alloc_req, rel_valid, rel_preg0, rel_preg1,
    output alloc_valid, alloc_preg, stall, ready, free_count, err
  );
endinterface

// File: rtl/preg_free_list.sv
// Physical-register free list: a self-initialising FIFO of free IDs with one grant and up
// to two releases per cycle; a presence bitmap screens out double frees and drives err.
module preg_free_list (
  input  logic            clk_i,
  input  logic            rst_i,
  preg_free_list_if.slave bus
);
  localparam int unsigned FL_DEPTH  = 32;
  localparam logic [5:0]  AREG_BASE = 6'd32;
  localparam logic [5:0]  LAST_INIT = 6'd31;
  localparam logic [6:0]  CAPACITY  = 7'd32;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  fl_q [FL_DEPTH];
  logic [4:0]  head_q, head_d;
  logic [4:0]  tail_q, tail_d;
  logic [5:0]  count_q, count_d;
  logic [63:0] free_map_q, free_map_d;
  logic        err_q, err_d;

  logic        run_s;
  logic        alloc_valid_s;
  logic        grant_s;
  logic [5:0]  head_preg_s;
  logic        ok0_s, ok1_s;
  logic        bad_s;
  logic [1:0]  ok_n_s;
  logic        ovf_s;
  logic        acc0_s, acc1_s;
  logic [1:0]  acc_n_s;
  logic        wr0_en_s, wr1_en_s;
  logic [5:0]  wr0_data_s, wr1_data_s;
  logic [4:0]  wr1_idx_s;

  // Grant and release screening; p0 is never accepted and a same-cycle duplicate on port1 loses
  always_comb begin
    run_s         = (state_q == ST_RUN);
    alloc_valid_s = run_s && (count_q != 6'd0);
    grant_s       = bus.alloc_req && alloc_valid_s;
    head_preg_s   = fl_q[head_q];
    ok0_s = bus.rel_valid[0] && (bus.rel_preg0 != 6'd0) && !free_map_q[bus.rel_preg0];
    ok1_s = bus.rel_valid[1] && (bus.rel_preg1 != 6'd0) && !free_map_q[bus.rel_preg1]
            && !(bus.rel_valid[0] && (bus.rel_preg1 == bus.rel_preg0));
    bad_s = (bus.rel_valid[0] && (bus.rel_preg0 != 6'd0) && !ok0_s)
         || (bus.rel_valid[1] && (bus.rel_preg1 != 6'd0) && !ok1_s);
    ok_n_s    = {1'b0, ok0_s} + {1'b0, ok1_s};
    ovf_s     = ({1'b0, count_q} + {5'd0, ok_n_s}) > CAPACITY;
    acc0_s    = run_s && ok0_s && !ovf_s;
    acc1_s    = run_s && ok1_s && !ovf_s;
    acc_n_s   = {1'b0, acc0_s} + {1'b0, acc1_s};
    wr1_idx_s = tail_q + 5'd1;
  end

  // Next-state: INIT pushes NUM_AREG+k each cycle, RUN pops the head and appends accepted releases
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    free_map_d = free_map_q;
    err_d      = err_q;
    wr0_en_s   = 1'b0;
    wr0_data_s = 6'd0;
    wr1_en_s   = 1'b0;
    wr1_data_s = 6'd0;
    case (state_q)
      ST_INIT: begin
        wr0_en_s   = 1'b1;
        wr0_data_s = AREG_BASE + count_q;
        tail_d     = tail_q + 5'd1;
        count_d    = count_q + 6'd1;
        if (bus.rel_valid != 2'b00) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (count_q == LAST_INIT) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN: begin
        if (acc0_s) begin
          wr0_en_s   = 1'b1;
          wr0_data_s = bus.rel_preg0;
          wr1_en_s   = acc1_s;
          wr1_data_s = bus.rel_preg1;
        end else if (acc1_s) begin
          wr0_en_s   = 1'b1;
          wr0_data_s = bus.rel_preg1;
        end else begin
          wr0_en_s   = 1'b0;
        end
        head_d  = head_q + {4'd0, grant_s};
        tail_d  = tail_q + {3'd0, acc_n_s};
        count_d = count_q - {5'd0, grant_s} + {4'd0, acc_n_s};
        if (bad_s || ovf_s) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (grant_s) begin
          free_map_d[head_preg_s] = 1'b0;
        end else begin
          free_map_d[head_preg_s] = free_map_q[head_preg_s];
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
    if (wr0_en_s) begin
      free_map_d[wr0_data_s] = 1'b1;
    end else begin
      free_map_d[wr0_data_s] = free_map_d[wr0_data_s];
    end
    if (wr1_en_s) begin
      free_map_d[wr1_data_s] = 1'b1;
    end else begin
      free_map_d[wr1_data_s] = free_map_d[wr1_data_s];
    end
  end

  // Control registers; reset empties the list and restarts initialisation
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_INIT;
      head_q     <= 5'd0;
      tail_q     <= 5'd0;
      count_q    <= 6'd0;
      free_map_q <= 64'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      free_map_q <= free_map_d;
      err_q      <= err_d;
    end
  end

  // List storage needs no reset: every slot is rewritten during INIT before it can be read
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr0_en_s) begin
      fl_q[tail_q] <= wr0_data_s;
    end
    if (!rst_i && wr1_en_s) begin
      fl_q[wr1_idx_s] <= wr1_data_s;
    end
  end

  // Grant is same-cycle, so alloc_valid/alloc_preg/stall are combinational from the head
  always_comb begin
    bus.alloc_valid = alloc_valid_s;
    if (alloc_valid_s) begin
      bus.alloc_preg = head_preg_s;
    end else begin
      bus.alloc_preg = 6'd0;
    end
    bus.stall      = bus.alloc_req && !grant_s;
    bus.ready      = run_s;
    bus.free_count = count_q;
    bus.err        = err_q;
  end
endmodule

// File: tb/tb_preg_free_list.sv
// Bench for preg_free_list: directed sequences and a vector table checked against constants,
// then randomised traffic checked every cycle against a queue-based reference model.
module tb_preg_free_list;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  preg_free_list_if bus ();

  preg_free_list dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       req;
    logic [1:0] rv;
    logic [5:0] p0;
    logic [5:0] p1;
    logic       valid;
    logic [5:0] preg;
    logic       stall;
    logic [5:0] cnt;
    logic       err;
  } vec_t;

  vec_t vecs [17];

  // Reference model: the list is an ordered queue of free IDs
  int q[$];
  int held[$];
  bit m_known;
  bit m_run;
  int m_k;
  bit m_err;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit in_list(input int id);
    foreach (q[i]) if (q[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input bit r, input bit req, input bit [1:0] rv,
                            input int p0, input int p1);
    bit g;
    bit a0;
    bit a1;
    if (r) begin
      q.delete();
      held.delete();
      m_run = 1'b0;
      m_k = 0;
      m_err = 1'b0;
      m_known = 1'b1;
    end else if (!m_known) begin
      m_known = 1'b0;
    end else if (!m_run) begin
      q.push_back(32 + m_k);
      m_k++;
      if (rv != 2'b00) m_err = 1'b1;
      if (m_k == 32) m_run = 1'b1;
    end else begin
      g  = req && (q.size() != 0);
      a0 = rv[0] && (p0 != 0) && !in_list(p0);
      a1 = rv[1] && (p1 != 0) && !in_list(p1) && !(rv[0] && (p1 == p0));
      if ((rv[0] && p0 != 0 && !a0) || (rv[1] && p1 != 0 && !a1)) m_err = 1'b1;
      if (q.size() + int'(a0) + int'(a1) > 32) begin
        m_err = 1'b1;
        a0 = 1'b0;
        a1 = 1'b0;
      end
      if (g) begin
        held.push_back(q[0]);
        void'(q.pop_front());
      end
      if (a0) q.push_back(p0);
      if (a1) q.push_back(p1);
    end
  endtask

  task automatic set_in(input bit r, input bit req, input bit [1:0] rv,
                        input logic [5:0] p0, input logic [5:0] p1);
    rst           = r;
    bus.alloc_req = req;
    bus.rel_valid = rv;
    bus.rel_preg0 = p0;
    bus.rel_preg1 = p1;
    #1;
  endtask

  task automatic tick();
    bit m_valid;
    int m_preg;
    if (m_known) begin
      m_valid = m_run && (q.size() != 0);
      m_preg  = m_valid ? q[0] : 0;
      chk("model_valid", int'(bus.alloc_valid), int'(m_valid));
      chk("model_preg",  int'(bus.alloc_preg), m_preg);
      chk("model_stall", int'(bus.stall), int'(bus.alloc_req && !m_valid));
      chk("model_ready", int'(bus.ready), int'(m_run));
      chk("model_count", int'(bus.free_count), q.size());
      chk("model_err",   int'(bus.err), int'(m_err));
    end
    @(posedge clk);
    model_step(rst, bus.alloc_req, bus.rel_valid, int'(bus.rel_preg0), int'(bus.rel_preg1));
    @(negedge clk);
  endtask

  initial begin
    bit         r;
    bit         req;
    bit [1:0]   rv;
    logic [5:0] p [2];
    int         idx;

    n_chk = 0;
    n_err = 0;
    m_known = 1'b0;
    m_run = 1'b0;
    m_k = 0;
    m_err = 1'b0;

    //            req   rv     p0     p1     valid preg   stall cnt    err
    vecs[0]  = '{1'b1, 2'd3, 6'd5,  6'd7,  1'b0, 6'd0,  1'b1, 6'd0, 1'b0};
    vecs[1]  = '{1'b1, 2'd0, 6'd0,  6'd0,  1'b1, 6'd5,  1'b0, 6'd2, 1'b0};
    vecs[2]  = '{1'b1, 2'd0, 6'd0,  6'd0,  1'b1, 6'd7,  1'b0, 6'd1, 1'b0};
    vecs[3]  = '{1'b0, 2'd1, 6'd20, 6'd0,  1'b0, 6'd0,  1'b0, 6'd0, 1'b0};
    vecs[4]  = '{1'b1, 2'd1, 6'd9,  6'd0,  1'b1, 6'd20, 1'b0, 6'd1, 1'b0};
    vecs[5]  = '{1'b0, 2'd0, 6'd0,  6'd0,  1'b1, 6'd9,  1'b0, 6'd1, 1'b0};
    vecs[6]  = '{1'b1, 2'd0, 6'd0,  6'd0,  1'b1, 6'd9,  1'b0, 6'd1, 1'b0};
    vecs[7]  = '{1'b0, 2'd1, 6'd40, 6'd0,  1'b0, 6'd0,  1'b0, 6'd0, 1'b0};
    vecs[8]  = '{1'b0, 2'd2, 6'd0,  6'd40, 1'b1, 6'd40, 1'b0, 6'd1, 1'b0};
    vecs[9]  = '{1'b0, 2'd3, 6'd12, 6'd12, 1'b1, 6'd40, 1'b0, 6'd1, 1'b1};
    vecs[10] = '{1'b0, 2'd1, 6'd0,  6'd0,  1'b1, 6'd40, 1'b0, 6'd2, 1'b1};
    vecs[11] = '{1'b0, 2'd0, 6'd0,  6'd0,  1'b1, 6'd40, 1'b0, 6'd2, 1'b1};
    vecs[12] = '{1'b1, 2'd0, 6'd0,  6'd0,  1'b1, 6'd40, 1'b0, 6'd2, 1'b1};
    vecs[13] = '{1'b1, 2'd0, 6'd0,  6'd0,  1'b1, 6'd12, 1'b0, 6'd1, 1'b1};
    vecs[14] = '{1'b1, 2'd0, 6'd0,  6'd0,  1'b0, 6'd0,  1'b1, 6'd0, 1'b1};
    vecs[15] = '{1'b0, 2'd2, 6'd0,  6'd0,  1'b0, 6'd0,  1'b0, 6'd0, 1'b1};
    vecs[16] = '{1'b0, 2'd0, 6'd0,  6'd0,  1'b0, 6'd0,  1'b0, 6'd0, 1'b1};

    // Reset for two cycles, then 32 INIT cycles with occasional requests that must stall
    set_in(1'b1, 1'b0, 2'd0, 6'd0, 6'd0);
    tick();
    set_in(1'b1, 1'b0, 2'd0, 6'd0, 6'd0);
    tick();
    for (int i = 0; i < 32; i++) begin
      set_in(1'b0, (i % 4) == 0, 2'd0, 6'd0, 6'd0);
      chk("init_ready", int'(bus.ready), 0);
      chk("init_count", int'(bus.free_count), i);
      chk("init_stall", int'(bus.stall), int'((i % 4) == 0));
      chk("init_valid", int'(bus.alloc_valid), 0);
      chk("init_preg",  int'(bus.alloc_preg), 0);
      tick();
    end
    set_in(1'b0, 1'b0, 2'd0, 6'd0, 6'd0);
    chk("ready_up",   int'(bus.ready), 1);
    chk("full_count", int'(bus.free_count), 32);
    chk("first_head", int'(bus.alloc_preg), 32);
    chk("init_err",   int'(bus.err), 0);
    tick();

    // Drain: 32 grants in order, then stall on the 33rd request
    for (int i = 0; i < 33; i++) begin
      set_in(1'b0, 1'b1, 2'd0, 6'd0, 6'd0);
      chk("drain_valid", int'(bus.alloc_valid), int'(i < 32));
      chk("drain_preg",  int'(bus.alloc_preg), (i < 32) ? 32 + i : 0);
      chk("drain_stall", int'(bus.stall), int'(i == 32));
      chk("drain_count", int'(bus.free_count), 32 - i);
      tick();
    end

    // Refill/wrap, simultaneous grant+release at count 1, protocol errors
    for (int v = 0; v < 17; v++) begin
      set_in(1'b0, vecs[v].req, vecs[v].rv, vecs[v].p0, vecs[v].p1);
      chk($sformatf("vec%0d_valid", v), int'(bus.alloc_valid), int'(vecs[v].valid));
      chk($sformatf("vec%0d_preg", v),  int'(bus.alloc_preg), int'(vecs[v].preg));
      chk($sformatf("vec%0d_stall", v), int'(bus.stall), int'(vecs[v].stall));
      chk($sformatf("vec%0d_count", v), int'(bus.free_count), int'(vecs[v].cnt));
      chk($sformatf("vec%0d_err", v),   int'(bus.err), int'(vecs[v].err));
      tick();
    end

    // Mid-run reset: free 1..10, grant them back, then reset with err still set
    for (int k = 0; k < 5; k++) begin
      set_in(1'b0, 1'b0, 2'd3, 6'(2 * k + 1), 6'(2 * k + 2));
      chk("mid_fill_count", int'(bus.free_count), 2 * k);
      tick();
    end
    for (int j = 0; j < 10; j++) begin
      set_in(1'b0, 1'b1, 2'd0, 6'd0, 6'd0);
      chk("mid_grant_preg",  int'(bus.alloc_preg), j + 1);
      chk("mid_grant_count", int'(bus.free_count), 10 - j);
      tick();
    end
    set_in(1'b1, 1'b0, 2'd0, 6'd0, 6'd0);
    chk("pre_reset_err", int'(bus.err), 1);
    tick();
    for (int i = 0; i < 32; i++) begin
      set_in(1'b0, 1'b0, 2'd0, 6'd0, 6'd0);
      chk("reinit_ready", int'(bus.ready), 0);
      chk("reinit_count", int'(bus.free_count), i);
      chk("reinit_err",   int'(bus.err), 0);
      tick();
    end
    for (int j = 0; j < 32; j++) begin
      set_in(1'b0, 1'b1, 2'd0, 6'd0, 6'd0);
      chk("refill_ready", int'(bus.ready), 1);
      chk("refill_preg",  int'(bus.alloc_preg), 32 + j);
      chk("refill_count", int'(bus.free_count), 32 - j);
      tick();
    end

    // Random traffic: mostly genuine frees of held registers, some bogus IDs, rare resets
    for (int c = 0; c < 800; c++) begin
      r   = ($urandom_range(0, 299) == 0);
      req = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 2; k++) begin
        rv[k] = ($urandom_range(0, 2) == 0);
        if (rv[k] && held.size() != 0 && $urandom_range(0, 4) != 0) begin
          idx = $urandom_range(0, held.size() - 1);
          p[k] = 6'(held[idx]);
          held.delete(idx);
        end else begin
          p[k] = 6'($urandom_range(0, 63));
        end
      end
      set_in(r, req, rv, p[0], p[1]);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
